// File: rtl/bg_scroll_ctrl.sv
// bg_scroll_ctrl
//   Scroll sequencer for the background-strip ROM. A small game-state FSM
//   holds a per-frame horizontal scroll offset. The ROM address for the
//   current VGA pixel is built from that offset and the counters, with the
//   column wrapped to the image width. The address is registered, and a
//   band-valid flag is delayed by two edges so that it lines up with the
//   one-cycle read latency of the synchronous ROM.
//
// Ports
//   clk            pixel clock; all state changes on its rising edge
//   rst_n          synchronous active-low reset
//   hcounter       VGA horizontal counter (11 bits)
//   vcounter       VGA vertical counter (11 bits)
//   game_start     one-cycle pulse: IDLE -> RUN
//   game_over      one-cycle pulse: RUN -> FREEZE
//   game_reset     one-cycle pulse: RUN/FREEZE -> IDLE, offset cleared
//   speed          (only with BG_SCROLL_SPEED_EN) per-tick increment minus one
//   addra          registered ROM address (15 bits)
//   band_valid     ROM data on the bus belongs to the strip pixel
//   scroll_offset  current offset, 0..IMG_W-1
//   run_state      FSM state: 00 IDLE, 01 RUN, 10 FREEZE
//
// Build option
//   BG_SCROLL_SPEED_EN: when defined, adds the speed[1:0] input. Each tick
//   in RUN then advances the offset by speed+1 instead of STEP.
module bg_scroll_ctrl #(
    parameter int BAND_TOP   = 310,
    parameter int BAND_BOT   = 450,
    parameter int H_ACTIVE   = 640,
    parameter int IMG_W      = 320,
    parameter int FRAME_LINE = 480,
    parameter int STEP       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcounter,
    input  logic [10:0] vcounter,
    input  logic        game_start,
    input  logic        game_over,
    input  logic        game_reset,
`ifdef BG_SCROLL_SPEED_EN
    input  logic [1:0]  speed,
`endif
    output logic [14:0] addra,
    output logic        band_valid,
    output logic [8:0]  scroll_offset,
    output logic [1:0]  run_state
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_FREEZE = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [8:0]  offset_q, offset_d;
    logic [14:0] addr_q, addr_d;
    logic        v1_q, valid_q;

    logic        frame_tick;
    logic [9:0]  inc;
    logic [9:0]  off_sum;
    logic [8:0]  off_next;

    // Fires once per frame, on a line outside active video, so the offset
    // is constant across every visible pixel.
    assign frame_tick = (vcounter == 11'(FRAME_LINE)) && (hcounter == 11'd0);

`ifdef BG_SCROLL_SPEED_EN
    assign inc = {8'd0, speed} + 10'd1;
`else
    assign inc = 10'(STEP);
`endif

    // The increment never exceeds IMG_W, so a single subtraction wraps.
    assign off_sum  = {1'b0, offset_q} + inc;
    assign off_next = (off_sum >= 10'(IMG_W)) ? 9'(off_sum - 10'(IMG_W))
                                              : off_sum[8:0];

    // Priority: game_reset > game_over > game_start > frame_tick.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        case (state_q)
            S_IDLE: begin
                offset_d = '0;
                if (!game_reset && game_start) state_d = S_RUN;
            end
            S_RUN: begin
                if (game_reset) begin
                    state_d  = S_IDLE;
                    offset_d = '0;
                end else if (game_over) begin
                    state_d = S_FREEZE;
                end else if (frame_tick) begin
                    offset_d = off_next;
                end
            end
            S_FREEZE: begin
                if (game_reset) begin
                    state_d  = S_IDLE;
                    offset_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                offset_d = '0;
            end
        endcase
    end

    // Address generation. The ROM image is stored at half resolution, so
    // both counters are halved before they index it.
    logic        in_band;
    logic [9:0]  col_sum, col, row;

    assign in_band = (hcounter < 11'(H_ACTIVE)) &&
                     (vcounter >= 11'(BAND_TOP)) &&
                     (vcounter < 11'(BAND_BOT));
    assign col_sum = hcounter[10:1] + {1'b0, offset_q};
    assign col     = (col_sum >= 10'(IMG_W)) ? col_sum - 10'(IMG_W) : col_sum;
    assign row     = vcounter[10:1] - 10'(BAND_TOP / 2);
    assign addr_d  = in_band ? (15'(row) * 15'(IMG_W) + 15'(col)) : 15'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            offset_q <= '0;
            addr_q   <= '0;
            v1_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
            // The first stage follows the address register. The second
            // stage follows the ROM output register.
            v1_q     <= in_band;
            valid_q  <= v1_q;
        end
    end

    assign addra         = addr_q;
    assign band_valid    = valid_q;
    assign scroll_offset = offset_q;
    assign run_state     = state_q;

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Directed testbench for bg_scroll_ctrl. Inputs change 1 ns after a rising
// edge, and outputs are sampled at that same point.
module tb_bg_scroll_ctrl;

    logic        clk;
    logic        rst_n;
    logic [10:0] hcounter;
    logic [10:0] vcounter;
    logic        game_start;
    logic        game_over;
    logic        game_reset;
`ifdef BG_SCROLL_SPEED_EN
    logic [1:0]  speed;
`endif
    logic [14:0] addra;
    logic        band_valid;
    logic [8:0]  scroll_offset;
    logic [1:0]  run_state;

    int checks = 0;
    int errors = 0;

    bg_scroll_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hcounter      (hcounter),
        .vcounter      (vcounter),
        .game_start    (game_start),
        .game_over     (game_over),
        .game_reset    (game_reset),
`ifdef BG_SCROLL_SPEED_EN
        .speed         (speed),
`endif
        .addra         (addra),
        .band_valid    (band_valid),
        .scroll_offset (scroll_offset),
        .run_state     (run_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame tick. The counters are then parked outside the band.
    task automatic do_tick();
        vcounter = 11'd480;
        hcounter = 11'd0;
        step();
        vcounter = 11'd0;
    endtask

    task automatic pulse_start();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    task automatic pulse_over();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
    endtask

    task automatic pulse_reset();
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        hcounter = 11'd0;
        vcounter = 11'd310;
        step();
        step();
        checks++; if (run_state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d exp 0", run_state); end
        checks++; if (scroll_offset !== 9'd0) begin errors++; $display("FAIL reset_offset got %0d exp 0", scroll_offset); end
        checks++; if (addra !== 15'd0) begin errors++; $display("FAIL reset_addra got %0d exp 0", addra); end
        checks++; if (band_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", band_valid); end
    endtask

    task automatic test_band();
        rst_n = 1'b1;
        hcounter = 11'd0;
        vcounter = 11'd310;
        step();
        checks++; if (addra !== 15'd0) begin errors++; $display("FAIL band_addr0 got %0d exp 0", addra); end
        checks++; if (band_valid !== 1'b0) begin errors++; $display("FAIL band_valid_lat1 got %0b exp 0", band_valid); end
        // row 1, col 5 -> 325
        hcounter = 11'd10;
        vcounter = 11'd312;
        step();
        checks++; if (band_valid !== 1'b1) begin errors++; $display("FAIL band_valid_lat2 got %0b exp 1", band_valid); end
        checks++; if (addra !== 15'd325) begin errors++; $display("FAIL band_addr325 got %0d exp 325", addra); end
        vcounter = 11'd309;
        step();
        step();
        checks++; if (band_valid !== 1'b0) begin errors++; $display("FAIL band_above got %0b exp 0", band_valid); end
        checks++; if (addra !== 15'd0) begin errors++; $display("FAIL band_above_addr got %0d exp 0", addra); end
        vcounter = 11'd450;
        step();
        step();
        checks++; if (band_valid !== 1'b0) begin errors++; $display("FAIL band_below got %0b exp 0", band_valid); end
        checks++; if (addra !== 15'd0) begin errors++; $display("FAIL band_below_addr got %0d exp 0", addra); end
        hcounter = 11'd640;
        vcounter = 11'd320;
        step();
        checks++; if (addra !== 15'd0) begin errors++; $display("FAIL band_hblank_addr got %0d exp 0", addra); end
    endtask

    task automatic test_scroll();
        pulse_start();
        checks++; if (run_state !== 2'b01) begin errors++; $display("FAIL scroll_run got %0d exp 1", run_state); end
        for (int i = 0; i < 3; i++) do_tick();
        checks++; if (scroll_offset !== 9'd3) begin errors++; $display("FAIL scroll_off3 got %0d exp 3", scroll_offset); end
        // col 319+3 = 322 wraps to 2
        hcounter = 11'd638;
        vcounter = 11'd310;
        step();
        checks++; if (addra !== 15'd2) begin errors++; $display("FAIL scroll_wrapcol got %0d exp 2", addra); end
        // last row: 69*320 + 3
        hcounter = 11'd0;
        vcounter = 11'd449;
        step();
        checks++; if (addra !== 15'd22083) begin errors++; $display("FAIL scroll_lastrow got %0d exp 22083", addra); end
        // no tick on line 479 or at hcounter 1 of line 480
        vcounter = 11'd479;
        step();
        hcounter = 11'd1;
        vcounter = 11'd480;
        step();
        checks++; if (scroll_offset !== 9'd3) begin errors++; $display("FAIL scroll_notick got %0d exp 3", scroll_offset); end
    endtask

    task automatic test_wrap();
        int exp_off;
        exp_off = 3;
        for (int i = 0; i < 316; i++) begin
            do_tick();
            exp_off++;
            checks++; if (scroll_offset !== 9'(exp_off)) begin errors++; $display("FAIL wrap_ramp got %0d exp %0d", scroll_offset, exp_off); end
        end
        checks++; if (scroll_offset !== 9'd319) begin errors++; $display("FAIL wrap_319 got %0d exp 319", scroll_offset); end
        do_tick();
        checks++; if (scroll_offset !== 9'd0) begin errors++; $display("FAIL wrap_0 got %0d exp 0", scroll_offset); end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 10; i++) do_tick();
        checks++; if (scroll_offset !== 9'd10) begin errors++; $display("FAIL frz_pre got %0d exp 10", scroll_offset); end
        vcounter = 11'd480;
        hcounter = 11'd0;
        pulse_over();
        vcounter = 11'd0;
        checks++; if (run_state !== 2'b10) begin errors++; $display("FAIL frz_state got %0d exp 2", run_state); end
        checks++; if (scroll_offset !== 9'd10) begin errors++; $display("FAIL frz_noadv got %0d exp 10", scroll_offset); end
        do_tick();
        do_tick();
        checks++; if (scroll_offset !== 9'd10) begin errors++; $display("FAIL frz_hold got %0d exp 10", scroll_offset); end
        pulse_start();
        checks++; if (run_state !== 2'b10) begin errors++; $display("FAIL frz_ign_start got %0d exp 2", run_state); end
        pulse_reset();
        checks++; if (run_state !== 2'b00) begin errors++; $display("FAIL frz_reset_state got %0d exp 0", run_state); end
        checks++; if (scroll_offset !== 9'd0) begin errors++; $display("FAIL frz_reset_off got %0d exp 0", scroll_offset); end
        do_tick();
        pulse_over();
        checks++; if (run_state !== 2'b00) begin errors++; $display("FAIL idle_ign_over got %0d exp 0", run_state); end
        checks++; if (scroll_offset !== 9'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", scroll_offset); end
    endtask

    task automatic test_start_tick();
        vcounter = 11'd480;
        hcounter = 11'd0;
        pulse_start();
        vcounter = 11'd0;
        checks++; if (run_state !== 2'b01) begin errors++; $display("FAIL st_state got %0d exp 1", run_state); end
        checks++; if (scroll_offset !== 9'd0) begin errors++; $display("FAIL st_noadv got %0d exp 0", scroll_offset); end
        do_tick();
        do_tick();
        pulse_reset();
        checks++; if (run_state !== 2'b00) begin errors++; $display("FAIL run_reset_state got %0d exp 0", run_state); end
        checks++; if (scroll_offset !== 9'd0) begin errors++; $display("FAIL run_reset_off got %0d exp 0", scroll_offset); end
    endtask

    task automatic test_mid_reset();
        pulse_start();
        for (int i = 0; i < 57; i++) do_tick();
        checks++; if (scroll_offset !== 9'd57) begin errors++; $display("FAIL mr_pre got %0d exp 57", scroll_offset); end
        hcounter = 11'd100;
        vcounter = 11'd320;
        step();
        step();
        checks++; if (band_valid !== 1'b1) begin errors++; $display("FAIL mr_inband got %0b exp 1", band_valid); end
        // row 5, col 50+57 = 107 -> 1707
        checks++; if (addra !== 15'd1707) begin errors++; $display("FAIL mr_addr got %0d exp 1707", addra); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (run_state !== 2'b00) begin errors++; $display("FAIL mr_state got %0d exp 0", run_state); end
        checks++; if (scroll_offset !== 9'd0) begin errors++; $display("FAIL mr_off got %0d exp 0", scroll_offset); end
        checks++; if (addra !== 15'd0) begin errors++; $display("FAIL mr_addra got %0d exp 0", addra); end
        checks++; if (band_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %0b exp 0", band_valid); end
    endtask

`ifdef BG_SCROLL_SPEED_EN
    task automatic test_speed();
        speed = 2'd3;
        pulse_start();
        for (int i = 0; i < 80; i++) do_tick();
        checks++; if (scroll_offset !== 9'd0) begin errors++; $display("FAIL spd_80 got %0d exp 0", scroll_offset); end
        do_tick();
        checks++; if (scroll_offset !== 9'd4) begin errors++; $display("FAIL spd_81 got %0d exp 4", scroll_offset); end
        speed = 2'd0;
        do_tick();
        checks++; if (scroll_offset !== 9'd5) begin errors++; $display("FAIL spd_s0 got %0d exp 5", scroll_offset); end
        pulse_reset();
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        hcounter   = 11'd0;
        vcounter   = 11'd0;
        game_start = 1'b0;
        game_over  = 1'b0;
        game_reset = 1'b0;
`ifdef BG_SCROLL_SPEED_EN
        speed      = 2'd0;
`endif
        test_reset();
        test_band();
        test_scroll();
        test_wrap();
        test_freeze();
        test_start_tick();
        test_mid_reset();
`ifdef BG_SCROLL_SPEED_EN
        test_speed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
